// File: rtl/drum_out_pio_pkg.sv
// Shared definitions for the drum/trigger output PIO: register word addresses.
package drum_out_pio_pkg;

    localparam int unsigned ADDR_W = 3;

    localparam logic [ADDR_W-1:0] REG_DATA      = 3'd0;
    localparam logic [ADDR_W-1:0] REG_SET       = 3'd1;
    localparam logic [ADDR_W-1:0] REG_CLEAR     = 3'd2;
    localparam logic [ADDR_W-1:0] REG_PULSE     = 3'd3;
    localparam logic [ADDR_W-1:0] REG_PULSE_LEN = 3'd4;
    localparam logic [ADDR_W-1:0] REG_IRQ_STAT  = 3'd5;
    localparam logic [ADDR_W-1:0] REG_IRQ_MASK  = 3'd6;

endpackage

// File: rtl/drum_pulse_chan.sv
// One retriggerable one-shot: loads len on a start request, counts down to zero,
// flags the natural 1->0 end so the top level can raise an interrupt.
module drum_pulse_chan #(
    parameter int unsigned PW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [PW-1:0] len,
    output logic          busy,
    output logic          done_pulse
);

    logic [PW-1:0] cnt_q, cnt_d;
    logic          load_eff;

    // A zero length must not abort a pulse already running.
    assign load_eff = load && (len != '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load_eff) begin
            cnt_d = len;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy       = (cnt_q != '0);
    assign done_pulse = (cnt_q == PW'(1)) && !load_eff;

endmodule

// File: rtl/drum_out_pio.sv
// Avalon-MM drum/trigger output PIO: static level bits with atomic set/clear plus
// per-channel one-shot pulses. Optional interrupt support under DRUM_OUT_PIO_IRQ_EN.
module drum_out_pio
    import drum_out_pio_pkg::*;
#(
    parameter int unsigned NUM_CH = 6,
    parameter int unsigned PW     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
`ifdef DRUM_OUT_PIO_IRQ_EN
    output logic              irq,
`endif
    output logic [NUM_CH-1:0] out_port
);

    logic              wr;
    logic [NUM_CH-1:0] wd_ch;
    logic [NUM_CH-1:0] data_q, data_d;
    logic [PW-1:0]     len_q, len_d;
    logic [NUM_CH-1:0] pulse_load;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] chan_done;
    logic [NUM_CH-1:0] irq_stat_rd;
    logic [NUM_CH-1:0] irq_mask_rd;
    logic              unused_wd;

    assign wr        = chipselect & ~write_n;
    assign wd_ch     = writedata[NUM_CH-1:0];
    assign unused_wd = ^writedata;

    always_comb begin
        data_d = data_q;
        len_d  = len_q;
        if (wr) begin
            case (address)
                REG_DATA:      data_d = wd_ch;
                REG_SET:       data_d = data_q | wd_ch;
                REG_CLEAR:     data_d = data_q & ~wd_ch;
                REG_PULSE_LEN: len_d  = writedata[PW-1:0];
                default:       ;
            endcase
        end
    end

    assign pulse_load = (wr && address == REG_PULSE) ? wd_ch : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            len_q  <= '0;
        end else begin
            data_q <= data_d;
            len_q  <= len_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        drum_pulse_chan #(
            .PW (PW)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .load       (pulse_load[i]),
            .len        (len_q),
            .busy       (busy[i]),
            .done_pulse (chan_done[i])
        );
    end

`ifdef DRUM_OUT_PIO_IRQ_EN
    logic [NUM_CH-1:0] irq_stat_q, irq_stat_d;
    logic [NUM_CH-1:0] irq_mask_q, irq_mask_d;

    // A pulse ending in the same cycle as a W1C keeps its status bit set.
    always_comb begin
        irq_stat_d = irq_stat_q;
        irq_mask_d = irq_mask_q;
        if (wr && address == REG_IRQ_STAT) begin
            irq_stat_d = irq_stat_q & ~wd_ch;
        end
        if (wr && address == REG_IRQ_MASK) begin
            irq_mask_d = wd_ch;
        end
        irq_stat_d = irq_stat_d | chan_done;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_stat_q <= '0;
            irq_mask_q <= '0;
        end else begin
            irq_stat_q <= irq_stat_d;
            irq_mask_q <= irq_mask_d;
        end
    end

    assign irq         = |(irq_stat_q & irq_mask_q);
    assign irq_stat_rd = irq_stat_q;
    assign irq_mask_rd = irq_mask_q;
`else
    logic unused_done;

    assign unused_done = ^chan_done;
    assign irq_stat_rd = '0;
    assign irq_mask_rd = '0;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            REG_DATA, REG_SET, REG_CLEAR: readdata = 32'(data_q);
            REG_PULSE:                    readdata = 32'(busy);
            REG_PULSE_LEN:                readdata = 32'(len_q);
            REG_IRQ_STAT:                 readdata = 32'(irq_stat_rd);
            REG_IRQ_MASK:                 readdata = 32'(irq_mask_rd);
            default:                      readdata = '0;
        endcase
    end

    assign out_port = data_q | busy;

endmodule

// File: tb/tb_drum_out_pio.sv
// Directed self-checking bench for drum_out_pio; the IRQ scenario runs only when
// DRUM_OUT_PIO_IRQ_EN is defined, otherwise the IRQ registers are checked to read zero.
module tb_drum_out_pio;
    import drum_out_pio_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [5:0]  out_port;
`ifdef DRUM_OUT_PIO_IRQ_EN
    logic        irq;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] rd;

    drum_out_pio #(
        .NUM_CH (6),
        .PW     (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
`ifdef DRUM_OUT_PIO_IRQ_EN
        .irq        (irq),
`endif
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    // Called at a negedge; the write is sampled at the next posedge, returns at the following negedge.
    task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
        address = addr;
        #1;
        data = readdata;
    endtask

    task automatic test_reset();
        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (out_port !== 6'h00) begin
            n_fail++; $display("FAIL reset_initial: out_port=0x%0h want 0x0", out_port);
        end
        bus_write(REG_DATA, 32'h2A);
        bus_write(REG_PULSE_LEN, 32'd5);
        bus_write(REG_PULSE, 32'h3F);
        n_checks++;
        if (out_port !== 6'h3F) begin
            n_fail++; $display("FAIL reset_pre: out_port=0x%0h want 0x3f", out_port);
        end
        // Reset concurrent with a DATA write: reset must win.
        reset = 1'b1; address = REG_DATA; writedata = 32'h15; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        n_checks++;
        if (out_port !== 6'h00) begin
            n_fail++; $display("FAIL reset_out: out_port=0x%0h want 0x0", out_port);
        end
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), rd);
            n_checks++;
            if (rd !== 32'h0) begin
                n_fail++; $display("FAIL reset_reg%0d: read=0x%0h want 0x0", a, rd);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_set_clear();
        bus_write(REG_DATA, 32'h05);
        bus_write(REG_CLEAR, 32'h01);
        bus_read(REG_DATA, rd);
        n_checks++;
        if (rd !== 32'h04) begin
            n_fail++; $display("FAIL clear: read=0x%0h want 0x4", rd);
        end
        @(negedge clk);
        bus_write(REG_SET, 32'h30);
        bus_read(REG_SET, rd);
        n_checks++;
        if (rd !== 32'h34) begin
            n_fail++; $display("FAIL set: read=0x%0h want 0x34", rd);
        end
        n_checks++;
        if (out_port !== 6'h34) begin
            n_fail++; $display("FAIL set_out: out_port=0x%0h want 0x34", out_port);
        end
        @(negedge clk);
        bus_write(REG_SET, 32'hFFFF_FFC0);
        bus_read(REG_CLEAR, rd);
        n_checks++;
        if (rd !== 32'h34) begin
            n_fail++; $display("FAIL set_high_bits: read=0x%0h want 0x34", rd);
        end
        @(negedge clk);
        bus_write(REG_DATA, 32'h0);
    endtask

    task automatic test_strobe();
        address = REG_DATA; writedata = 32'h3F; chipselect = 1'b0; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b1;
        @(negedge clk);
        chipselect = 1'b0;
        bus_read(REG_DATA, rd);
        n_checks++;
        if (rd !== 32'h0 || out_port !== 6'h00) begin
            n_fail++; $display("FAIL strobe: read=0x%0h out_port=0x%0h want 0x0", rd, out_port);
        end
        @(negedge clk);
    endtask

    task automatic test_pulse();
        bus_write(REG_PULSE_LEN, 32'd3);
        bus_read(REG_PULSE_LEN, rd);
        n_checks++;
        if (rd !== 32'd3) begin
            n_fail++; $display("FAIL pulse_len_rd: read=0x%0h want 0x3", rd);
        end
        @(negedge clk);
        bus_write(REG_PULSE, 32'h02);
        bus_read(REG_PULSE, rd);
        n_checks++;
        if (rd !== 32'h02) begin
            n_fail++; $display("FAIL pulse_busy: read=0x%0h want 0x2", rd);
        end
        for (int c = 1; c <= 5; c++) begin
            n_checks++;
            if (out_port !== ((c <= 3) ? 6'h02 : 6'h00)) begin
                n_fail++; $display("FAIL pulse_c%0d: out_port=0x%0h want 0x%0h",
                                   c, out_port, (c <= 3) ? 6'h02 : 6'h00);
            end
            @(negedge clk);
        end
        bus_read(REG_PULSE, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL pulse_idle: read=0x%0h want 0x0", rd);
        end
        @(negedge clk);
    endtask

    task automatic test_retrigger();
        bus_write(REG_PULSE_LEN, 32'd4);
        bus_write(REG_PULSE, 32'h01);
        n_checks++;
        if (out_port !== 6'h01) begin
            n_fail++; $display("FAIL retrig_c1: out_port=0x%0h want 0x1", out_port);
        end
        @(negedge clk);
        n_checks++;
        if (out_port !== 6'h01) begin
            n_fail++; $display("FAIL retrig_c2: out_port=0x%0h want 0x1", out_port);
        end
        bus_write(REG_PULSE, 32'h01);
        for (int c = 3; c <= 8; c++) begin
            n_checks++;
            if (out_port !== ((c <= 6) ? 6'h01 : 6'h00)) begin
                n_fail++; $display("FAIL retrig_c%0d: out_port=0x%0h want 0x%0h",
                                   c, out_port, (c <= 6) ? 6'h01 : 6'h00);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_len_change();
        bus_write(REG_PULSE_LEN, 32'd5);
        bus_write(REG_PULSE, 32'h04);
        bus_write(REG_PULSE_LEN, 32'd1);
        for (int c = 2; c <= 6; c++) begin
            n_checks++;
            if (out_port !== ((c <= 5) ? 6'h04 : 6'h00)) begin
                n_fail++; $display("FAIL lenchg_c%0d: out_port=0x%0h want 0x%0h",
                                   c, out_port, (c <= 5) ? 6'h04 : 6'h00);
            end
            @(negedge clk);
        end
        bus_write(REG_PULSE, 32'h04);
        n_checks++;
        if (out_port !== 6'h04) begin
            n_fail++; $display("FAIL lenchg_new1: out_port=0x%0h want 0x4", out_port);
        end
        @(negedge clk);
        n_checks++;
        if (out_port !== 6'h00) begin
            n_fail++; $display("FAIL lenchg_new2: out_port=0x%0h want 0x0", out_port);
        end
    endtask

    task automatic test_len_zero();
        bus_write(REG_PULSE_LEN, 32'd3);
        bus_write(REG_PULSE, 32'h01);
        bus_write(REG_PULSE_LEN, 32'd0);
        bus_write(REG_PULSE, 32'h01);
        n_checks++;
        if (out_port !== 6'h01) begin
            n_fail++; $display("FAIL len0_running: out_port=0x%0h want 0x1", out_port);
        end
        @(negedge clk);
        n_checks++;
        if (out_port !== 6'h00) begin
            n_fail++; $display("FAIL len0_end: out_port=0x%0h want 0x0", out_port);
        end
        bus_write(REG_DATA, 32'h08);
        bus_write(REG_PULSE, 32'h3F);
        bus_read(REG_PULSE, rd);
        n_checks++;
        if (rd !== 32'h0 || out_port !== 6'h08) begin
            n_fail++; $display("FAIL len0_pulse: busy=0x%0h out_port=0x%0h want 0x0/0x8",
                               rd, out_port);
        end
        @(negedge clk);
        bus_write(REG_DATA, 32'h0);
    endtask

    task automatic test_data_overlap();
        bus_write(REG_DATA, 32'h02);
        bus_write(REG_PULSE_LEN, 32'd2);
        bus_write(REG_PULSE, 32'h02);
        for (int c = 1; c <= 4; c++) begin
            n_checks++;
            if (out_port !== 6'h02) begin
                n_fail++; $display("FAIL overlap_c%0d: out_port=0x%0h want 0x2", c, out_port);
            end
            @(negedge clk);
        end
        bus_write(REG_DATA, 32'h0);
        n_checks++;
        if (out_port !== 6'h00) begin
            n_fail++; $display("FAIL overlap_off: out_port=0x%0h want 0x0", out_port);
        end
    endtask

`ifdef DRUM_OUT_PIO_IRQ_EN
    task automatic test_irq();
        bus_write(REG_IRQ_MASK, 32'h01);
        bus_read(REG_IRQ_MASK, rd);
        n_checks++;
        if (rd !== 32'h01) begin
            n_fail++; $display("FAIL irq_mask_rd: read=0x%0h want 0x1", rd);
        end
        @(negedge clk);
        bus_write(REG_PULSE_LEN, 32'd2);
        bus_write(REG_PULSE, 32'h01);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL irq_c1: irq=%0b want 0", irq);
        end
        @(negedge clk);
        n_checks++;
        if (irq !== 1'b0 || out_port !== 6'h01) begin
            n_fail++; $display("FAIL irq_c2: irq=%0b out_port=0x%0h want 0/0x1", irq, out_port);
        end
        @(negedge clk);
        bus_read(REG_IRQ_STAT, rd);
        n_checks++;
        if (irq !== 1'b1 || out_port !== 6'h00 || rd !== 32'h01) begin
            n_fail++; $display("FAIL irq_c3: irq=%0b out_port=0x%0h stat=0x%0h want 1/0x0/0x1",
                               irq, out_port, rd);
        end
        @(negedge clk);
        bus_write(REG_IRQ_STAT, 32'h01);
        bus_read(REG_IRQ_STAT, rd);
        n_checks++;
        if (irq !== 1'b0 || rd !== 32'h0) begin
            n_fail++; $display("FAIL irq_w1c: irq=%0b stat=0x%0h want 0/0x0", irq, rd);
        end
        @(negedge clk);
        bus_write(REG_PULSE, 32'h02);
        repeat (3) @(negedge clk);
        bus_read(REG_IRQ_STAT, rd);
        n_checks++;
        if (irq !== 1'b0 || rd !== 32'h02) begin
            n_fail++; $display("FAIL irq_masked: irq=%0b stat=0x%0h want 0/0x2", irq, rd);
        end
        @(negedge clk);
        bus_write(REG_IRQ_STAT, 32'h02);
    endtask
`else
    task automatic test_no_irq();
        bus_write(REG_IRQ_MASK, 32'h3F);
        bus_write(REG_IRQ_STAT, 32'h3F);
        bus_write(3'd7, 32'h3F);
        for (int a = 5; a < 8; a++) begin
            bus_read(3'(a), rd);
            n_checks++;
            if (rd !== 32'h0) begin
                n_fail++; $display("FAIL no_irq_reg%0d: read=0x%0h want 0x0", a, rd);
            end
        end
        n_checks++;
        if (out_port !== 6'h00) begin
            n_fail++; $display("FAIL no_irq_out: out_port=0x%0h want 0x0", out_port);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_set_clear();
        test_strobe();
        test_pulse();
        test_retrigger();
        test_len_change();
        test_len_zero();
        test_data_overlap();
`ifdef DRUM_OUT_PIO_IRQ_EN
        test_irq();
`else
        test_no_irq();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
